// File: rtl/config_bit_loader.sv
// Serial loader for the routing transmission-gate SRAM bits. Bits are shifted
// into a shadow register and only committed to sram_bits after a full frame.
module config_bit_loader #(
  parameter int unsigned N_BITS = 32,
  parameter int unsigned CNT_W  = $clog2(N_BITS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic              cfg_clear,
  input  logic              cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  cfg_count,
  output logic [N_BITS-1:0] sram_bits
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BITS - 1);

  state_e              state_q;
  logic [N_BITS-1:0]   shadow_q;
  logic [N_BITS-1:0]   sram_q;
  logic [CNT_W-1:0]    count_q;
  logic                done_q;
  logic                err_q;

  // Single-process FSM; priority is clear > abort > start > data beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      sram_q   <= '1;
      count_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (cfg_clear) begin
        sram_q  <= '1;
        state_q <= IDLE;
        count_q <= '0;
        err_q   <= (state_q != IDLE);
      end else if (cfg_abort && (state_q != IDLE)) begin
        state_q <= IDLE;
        count_q <= '0;
        err_q   <= 1'b1;
      end else if (cfg_start) begin
        // A start inside a frame discards it, including any same-cycle beat.
        state_q  <= SHIFT;
        count_q  <= '0;
        shadow_q <= '0;
        err_q    <= (state_q != IDLE);
      end else begin
        case (state_q)
          SHIFT: begin
            if (cfg_valid) begin
              shadow_q <= {shadow_q[N_BITS-2:0], cfg_data};
              count_q  <= count_q + CNT_W'(1);
              if (count_q == LAST_BEAT) begin
                state_q <= COMMIT;
              end
            end
          end
          COMMIT: begin
            sram_q  <= shadow_q;
            done_q  <= 1'b1;
            count_q <= '0;
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  // Handshake flags decode straight from the state register.
  assign cfg_ready = (state_q == SHIFT);
  assign cfg_busy  = (state_q == SHIFT) || (state_q == COMMIT);
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign cfg_count = count_q;
  assign sram_bits = sram_q;

endmodule

// File: tb/tb_config_bit_loader.sv
// Directed bench for config_bit_loader (N_BITS=8) with a commit scoreboard.
module tb_config_bit_loader;

  localparam int unsigned N_BITS = 8;
  localparam int unsigned CNT_W  = $clog2(N_BITS + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_start;
  logic              cfg_abort;
  logic              cfg_clear;
  logic              cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              cfg_busy;
  logic              cfg_done;
  logic              cfg_err;
  logic [CNT_W-1:0]  cfg_count;
  logic [N_BITS-1:0] sram_bits;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [N_BITS-1:0] exp_q[$];
  logic [N_BITS-1:0] cur_sram;

  config_bit_loader #(.N_BITS(N_BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_abort (cfg_abort),
    .cfg_clear (cfg_clear),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .cfg_count (cfg_count),
    .sram_bits (sram_bits)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Commit monitor: every cfg_done must match a queued frame; done and err never overlap.
  always begin
    @(posedge clk);
    #1;
    if (rst_n === 1'b1) begin
      tests++;
      assert (!(cfg_done === 1'b1 && cfg_err === 1'b1)) else begin
        fails++;
        $error("FAIL done_err_overlap observed=11 expected=not_both");
      end
      if (cfg_done === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $error("FAIL unexpected_done observed=%0h expected=no_done", sram_bits);
        end else begin
          logic [N_BITS-1:0] e;
          e = exp_q.pop_front();
          assert (sram_bits === e) else begin
            fails++;
            $error("FAIL sb_commit observed=%0h expected=%0h", sram_bits, e);
          end
        end
      end
    end
  end

  // Eight beats plus commit; gap inserts 3 idle-valid cycles after beat 4.
  task automatic frame_body(input logic [N_BITS-1:0] bits, input bit gap);
    for (int i = 0; i < N_BITS; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = bits[N_BITS-1-i];
      if (i == N_BITS - 1) exp_q.push_back(bits);
      cyc();
      chk("beat_count", 32'(cfg_count), 32'(i + 1));
      chk("sram_midframe", 32'(sram_bits), 32'(cur_sram));
      if (gap && i == 3) begin
        cfg_valid = 1'b0;
        cfg_data  = 1'b1;
        for (int g = 0; g < 3; g++) begin
          cyc();
          chk("gap_count", 32'(cfg_count), 32'd4);
        end
      end
    end
    cfg_valid = 1'b0;
    chk("commit_ready", 32'(cfg_ready), 32'd0);
    chk("commit_busy", 32'(cfg_busy), 32'd1);
    cyc();
    cur_sram = bits;
    chk("commit_done", 32'(cfg_done), 32'd1);
    chk("commit_sram", 32'(sram_bits), 32'(bits));
    chk("commit_count", 32'(cfg_count), 32'd0);
    chk("commit_idle", 32'(cfg_busy), 32'd0);
    cyc();
    chk("done_pulse_end", 32'(cfg_done), 32'd0);
  endtask

  task automatic start_pulse();
    cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    chk("start_ready", 32'(cfg_ready), 32'd1);
    chk("start_count", 32'(cfg_count), 32'd0);
  endtask

  task automatic beats(input int n, input logic d);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = d;
      cyc();
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_clear = 1'b0;
    cfg_data = 1'b0; cfg_valid = 1'b0;
    cur_sram = '1;
    cyc();
    cyc();
    chk("rst_sram", 32'(sram_bits), 32'hFF);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    chk("rst_busy", 32'(cfg_busy), 32'd0);
    chk("rst_done", 32'(cfg_done), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    chk("rst_count", 32'(cfg_count), 32'd0);
    rst_n = 1'b1;

    // Valid and abort in IDLE are ignored.
    cfg_valid = 1'b1; cfg_abort = 1'b1;
    cyc();
    cfg_valid = 1'b0; cfg_abort = 1'b0;
    chk("idle_count", 32'(cfg_count), 32'd0);
    chk("idle_abort_err", 32'(cfg_err), 32'd0);
    chk("idle_ready", 32'(cfg_ready), 32'd0);

    // Full frame, then gapped frame with the same data.
    start_pulse();
    frame_body(8'hB2, 1'b0);
    start_pulse();
    frame_body(8'hB2, 1'b1);

    // Abort mid-frame keeps the live bits.
    start_pulse();
    beats(5, 1'b0);
    chk("abort_pre_count", 32'(cfg_count), 32'd5);
    cfg_abort = 1'b1;
    cyc();
    cfg_abort = 1'b0;
    chk("abort_err", 32'(cfg_err), 32'd1);
    chk("abort_busy", 32'(cfg_busy), 32'd0);
    chk("abort_count", 32'(cfg_count), 32'd0);
    chk("abort_sram", 32'(sram_bits), 32'hB2);
    cyc();
    chk("abort_err_end", 32'(cfg_err), 32'd0);
    cyc();
    cyc();
    chk("abort_sram_hold", 32'(sram_bits), 32'hB2);

    // Restart with a concurrent beat, then an all-zero frame.
    start_pulse();
    beats(3, 1'b1);
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 1'b1;
    cyc();
    cfg_start = 1'b0; cfg_valid = 1'b0;
    chk("restart_err", 32'(cfg_err), 32'd1);
    chk("restart_count", 32'(cfg_count), 32'd0);
    chk("restart_ready", 32'(cfg_ready), 32'd1);
    frame_body(8'h00, 1'b0);

    cfg_clear = 1'b1;
    cyc();
    cfg_clear = 1'b0;
    cur_sram = '1;
    chk("clear_sram", 32'(sram_bits), 32'hFF);
    chk("clear_idle_err", 32'(cfg_err), 32'd0);

    // Clear and start together during SHIFT: clear wins.
    start_pulse();
    frame_body(8'h5A, 1'b0);
    start_pulse();
    beats(2, 1'b1);
    cfg_clear = 1'b1; cfg_start = 1'b1;
    cyc();
    cfg_clear = 1'b0; cfg_start = 1'b0;
    chk("simul_sram", 32'(sram_bits), 32'hFF);
    chk("simul_err", 32'(cfg_err), 32'd1);
    chk("simul_ready", 32'(cfg_ready), 32'd0);
    chk("simul_busy", 32'(cfg_busy), 32'd0);
    chk("simul_count", 32'(cfg_count), 32'd0);
    cyc();
    chk("simul_err_end", 32'(cfg_err), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
